// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin shared-adder arbiter.
package adder_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } t_arb_state;

  localparam int unsigned GRANT_CNT_W = 16;

  // Round-robin successor of idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/adder_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module adder_arb_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] mask;
  int unsigned          hit;
  logic                 any;

  // Lower copy masked below rr_ptr, upper copy full: lowest set bit is the wrapped winner.
  always_comb begin
    mask      = {(2*NUM_REQ){1'b1}} << rr_ptr;
    dbl       = {req, req} & mask;
    hit       = 0;
    any       = 1'b0;
    for (int unsigned k = 0; k < 2*NUM_REQ; k++) begin
      if (dbl[k] && !any) begin
        hit = k;
        any = 1'b1;
      end
    end
    grant_idx = IDX_W'((hit >= NUM_REQ) ? hit - NUM_REQ : hit);
    grant     = any ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// One registered WIDTH-bit adder shared by NUM_REQ requesters under round-robin arbitration.
// Optional per-requester grant counters: define ADDER_RR_ARBITER_STATS_EN.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]       req_a,
  input  logic [NUM_REQ*WIDTH-1:0]       req_b,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [WIDTH:0]                 rsp_sum,
  output logic [NUM_REQ*GRANT_CNT_W-1:0] grant_cnt
);

  t_arb_state         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               rsp_fire;
  logic               arb_open;
  logic               acc_fire;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH:0]     sum;

  adder_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Handshake decode and operand select for the current winner.
  always_comb begin
    rsp_fire  = (state == ARB_RESP) && rsp_valid[owner] && rsp_ready[owner];
    arb_open  = (state == ARB_IDLE) || rsp_fire;
    req_ready = grant & {NUM_REQ{arb_open && !reset}};
    acc_fire  = |(req_valid & req_ready);
    a_sel     = req_a[32'(grant_idx)*WIDTH +: WIDTH];
    b_sel     = req_b[32'(grant_idx)*WIDTH +: WIDTH];
    sum       = (WIDTH+1)'(a_sel) + (WIDTH+1)'(b_sel);
  end

  // Result register, ownership and round-robin pointer; a new accept overrides a draining response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      rsp_valid <= '0;
      rsp_sum   <= '0;
    end else if (acc_fire) begin
      state     <= ARB_RESP;
      owner     <= grant_idx;
      rsp_valid <= grant;
      rsp_sum   <= sum;
      rr_ptr    <= IDX_W'(rr_next(32'(grant_idx), NUM_REQ));
    end else if (rsp_fire) begin
      state     <= ARB_IDLE;
      rsp_valid <= '0;
    end
  end

`ifdef ADDER_RR_ARBITER_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [GRANT_CNT_W-1:0] cnt;

    // Saturating count of accepts for requester i.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt <= '0;
      end else if (req_valid[i] && req_ready[i] && (cnt != '1)) begin
        cnt <= cnt + GRANT_CNT_W'(1);
      end
    end

    assign grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] = cnt;
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter (NUM_REQ=4, WIDTH=4).
module tb_adder_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [4:0]  rsp_sum;
  logic [63:0] grant_cnt;

  int vectors     = 0;
  int miscompares = 0;

  adder_rr_arbiter #(
    .NUM_REQ (4),
    .WIDTH   (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .grant_cnt (grant_cnt)
  );

  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs are driven and outputs sampled away from it.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sums for a=16'h4321, b=16'h9753: req0 1+3, req1 2+5, req2 3+7, req3 4+9.
  logic [4:0] fair_sum [4] = '{5'h04, 5'h07, 5'h0A, 5'h0D};

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 4'b0000;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    tick();
    tick();

    // Reset state and req_ready gating
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_sum",   64'(rsp_sum),   64'h0);
    chk("rst_grant_cnt", grant_cnt,      64'h0);
    req_valid = 4'b0000;
    reset     = 1'b0;
    tick();

    // 1. Single requester
    req_valid = 4'b0010;
    req_a     = 16'h0070;
    req_b     = 16'h0050;
    rsp_ready = 4'b1111;
    #1;
    chk("single_req_ready", 64'(req_ready), 64'h2);
    tick();
    chk("single_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("single_rsp_sum",   64'(rsp_sum),   64'h0C);
    req_valid = 4'b0000;
    tick();
    chk("single_rsp_drop",  64'(rsp_valid), 64'h0);

    // 2. Fairness from reset
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_a     = 16'h4321;
    req_b     = 16'h9753;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("fair_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("fair_rsp_valid_%0d", k), 64'(rsp_valid), 64'(4'b0001 << (k % 4)));
      chk($sformatf("fair_rsp_sum_%0d", k), 64'(rsp_sum), 64'(fair_sum[k % 4]));
    end

    // 3. Backpressure on requester 2
    req_a     = 16'h4F21;
    req_b     = 16'h9F53;
    req_valid = 4'b0100;
    rsp_ready = 4'b1011;
    #1;
    chk("bp_grant2", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_hold_ready_%0d", k), 64'(req_ready), 64'h0);
      chk($sformatf("bp_hold_valid_%0d", k), 64'(rsp_valid), 64'h4);
      chk($sformatf("bp_hold_sum_%0d", k),   64'(rsp_sum),   64'h1E);
      tick();
    end
    rsp_ready = 4'b1111;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'h8);
    tick();
    chk("bp_next_valid", 64'(rsp_valid), 64'h8);
    chk("bp_next_sum",   64'(rsp_sum),   64'h0D);

    // 4. Wrap and skip: pointer parked at 3 after granting requester 2
    req_valid = 4'b0100;
    #1;
    chk("wrap_setup_ready", 64'(req_ready), 64'h4);
    tick();
    chk("wrap_setup_sum", 64'(rsp_sum), 64'h1E);
    req_valid = 4'b0101;
    #1;
    chk("wrap_ready_0", 64'(req_ready), 64'h1);
    tick();
    chk("wrap_valid_0", 64'(rsp_valid), 64'h1);
    chk("wrap_sum_0",   64'(rsp_sum),   64'h04);
    chk("wrap_ready_1", 64'(req_ready), 64'h4);
    tick();
    chk("wrap_valid_1", 64'(rsp_valid), 64'h4);
    chk("wrap_sum_1",   64'(rsp_sum),   64'h1E);
    chk("wrap_ready_2", 64'(req_ready), 64'h1);
    tick();
    chk("wrap_valid_2", 64'(rsp_valid), 64'h1);

    // 5. Reset while a result is held
    req_valid = 4'b0000;
    rsp_ready = 4'b0000;
    tick();
    chk("mid_held_valid", 64'(rsp_valid), 64'h1);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(rsp_valid), 64'h0);
    chk("mid_rst_sum",   64'(rsp_sum),   64'h0);
    reset     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    #1;
    chk("mid_first_ready", 64'(req_ready), 64'h1);
    tick();
    chk("mid_first_sum", 64'(rsp_sum), 64'h04);

    // 6. Back-to-back same requester and grant statistics
    reset     = 1'b1;
    req_valid = 4'b0000;
    tick();
    reset     = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("b2b_ready_%0d", k), 64'(req_ready), 64'h2);
      tick();
      chk($sformatf("b2b_valid_%0d", k), 64'(rsp_valid), 64'h2);
      chk($sformatf("b2b_sum_%0d", k),   64'(rsp_sum),   64'h07);
    end
    req_valid = 4'b0000;
    tick();
`ifdef ADDER_RR_ARBITER_STATS_EN
    chk("stats_cnt3", grant_cnt, 64'h0000_0000_0003_0000);
    req_valid = 4'b0010;
    repeat (65540) @(posedge clock);
    #2;
    req_valid = 4'b0000;
    tick();
    chk("stats_sat", grant_cnt, 64'h0000_0000_FFFF_0000);
`else
    chk("stats_off", grant_cnt, 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
